// File: rtl/synth_pkg.sv
// Shared types and elaboration-time tuning math for the polyphonic oscillator.
package synth_pkg;

    localparam int NOTE_W = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    function automatic real note_freq(input int m);
        return 440.0 * (2.0 ** ((real'(m) - 69.0) / 12.0));
    endfunction

    // Top-octave increment for semitone s, rounded to nearest. The value can exceed
    // 2^31, so it is rebuilt from two 16-bit-scaled halves to stay within $rtoi range.
    function automatic logic [63:0] base_inc(input int s, input int sample_rate, input int width);
        real inc_r;
        int  hi;
        int  lo;
        inc_r = note_freq(120 + s) * (2.0 ** width) / real'(sample_rate);
        hi    = $rtoi(inc_r / 65536.0);
        lo    = $rtoi(inc_r - real'(hi) * 65536.0 + 0.5);
        return 64'(hi) * 64'd65536 + 64'(lo);
    endfunction

endpackage

// File: rtl/note_to_increment.sv
// Combinational MIDI note to phase increment: top-octave table lookup, then octave shift.
module note_to_increment
    import synth_pkg::*;
#(
    parameter int PHASE_WIDTH    = 32,
    parameter int SAMPLE_RATE_HZ = 16384
) (
    input  logic [NOTE_W-1:0]      note_in,
    output logic [PHASE_WIDTH-1:0] inc_out
);

    localparam logic [63:0] BASE_INC [12] = '{
        base_inc(0,  SAMPLE_RATE_HZ, PHASE_WIDTH), base_inc(1,  SAMPLE_RATE_HZ, PHASE_WIDTH),
        base_inc(2,  SAMPLE_RATE_HZ, PHASE_WIDTH), base_inc(3,  SAMPLE_RATE_HZ, PHASE_WIDTH),
        base_inc(4,  SAMPLE_RATE_HZ, PHASE_WIDTH), base_inc(5,  SAMPLE_RATE_HZ, PHASE_WIDTH),
        base_inc(6,  SAMPLE_RATE_HZ, PHASE_WIDTH), base_inc(7,  SAMPLE_RATE_HZ, PHASE_WIDTH),
        base_inc(8,  SAMPLE_RATE_HZ, PHASE_WIDTH), base_inc(9,  SAMPLE_RATE_HZ, PHASE_WIDTH),
        base_inc(10, SAMPLE_RATE_HZ, PHASE_WIDTH), base_inc(11, SAMPLE_RATE_HZ, PHASE_WIDTH)
    };

    logic [3:0] semi;
    logic [3:0] oct;

    always_comb begin
        semi    = 4'(note_in % 7'd12);
        oct     = 4'(note_in / 7'd12);
        // Notes 120..127 sit in octave 10, the table's own octave, so the shift is 0 there.
        inc_out = PHASE_WIDTH'(BASE_INC[semi]) >> (4'd10 - oct);
    end

endmodule

// File: rtl/poly_phase_accumulator.sv
// Time-multiplexed polyphonic phase accumulator: one voice per cycle per sample tick,
// with a valid/ready command port for note-on/off.
module poly_phase_accumulator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES          = 8,
    parameter int PHASE_WIDTH         = 32,
    parameter int SAMPLE_RATE_HZ      = 16384,
    parameter bit PHASE_RESET_ON_NOTE = 1'b1
) (
    input  logic                                                 clk_in,
    input  logic                                                 rst_in,
    input  logic                                                 sample_tick_in,
    input  logic                                                 cmd_valid_in,
    output logic                                                 cmd_ready_out,
    input  logic [$clog2(NUM_VOICES > 1 ? NUM_VOICES : 2)-1:0]   cmd_voice_in,
    input  logic [NOTE_W-1:0]                                    cmd_note_in,
    input  logic                                                 cmd_gate_in,
    output logic [PHASE_WIDTH-1:0]                               phase_out,
    output logic [$clog2(NUM_VOICES > 1 ? NUM_VOICES : 2)-1:0]   voice_out,
    output logic                                                 phase_valid_out,
    output logic                                                 last_out,
    output logic [NUM_VOICES-1:0]                                active_mask_out,
    output logic                                                 overrun_out
);

    localparam int             VW       = $clog2(NUM_VOICES > 1 ? NUM_VOICES : 2);
    localparam logic [VW-1:0]  LAST_IDX = VW'(NUM_VOICES - 1);

    sweep_state_t           state_q, state_d;
    logic [VW-1:0]          idx_q, idx_d;
    logic [PHASE_WIDTH-1:0] phase_q [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] phase_d [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] inc_q   [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] inc_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0]  active_q, active_d;

    logic [PHASE_WIDTH-1:0] phase_out_q, phase_out_d;
    logic [VW-1:0]          voice_out_q, voice_out_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   overrun_q, overrun_d;

    logic [PHASE_WIDTH-1:0] note_inc;
    logic [PHASE_WIDTH-1:0] next_phase;
    logic                   cmd_accept;

    note_to_increment #(
        .PHASE_WIDTH    (PHASE_WIDTH),
        .SAMPLE_RATE_HZ (SAMPLE_RATE_HZ)
    ) u_note_to_increment (
        .note_in (cmd_note_in),
        .inc_out (note_inc)
    );

    assign cmd_accept = cmd_valid_in && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        phase_d     = phase_q;
        inc_d       = inc_q;
        active_d    = active_q;
        phase_out_d = phase_out_q;
        voice_out_d = voice_out_q;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        overrun_d   = overrun_q;
        next_phase  = '0;

        case (state_q)
            IDLE: begin
                // Commands land at this edge, so a same-cycle tick sweeps the updated voice.
                if (cmd_accept) begin
                    if (cmd_gate_in) begin
                        inc_d[cmd_voice_in]    = note_inc;
                        active_d[cmd_voice_in] = 1'b1;
                        if (PHASE_RESET_ON_NOTE) phase_d[cmd_voice_in] = '0;
                    end else begin
                        inc_d[cmd_voice_in]    = '0;
                        active_d[cmd_voice_in] = 1'b0;
                        phase_d[cmd_voice_in]  = '0;
                    end
                end
                if (sample_tick_in) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                next_phase     = active_q[idx_q] ? phase_q[idx_q] + inc_q[idx_q] : '0;
                phase_d[idx_q] = next_phase;
                phase_out_d    = next_phase;
                voice_out_d    = idx_q;
                valid_d        = 1'b1;
                last_d         = (idx_q == LAST_IDX);
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
                if (sample_tick_in) overrun_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            active_q    <= '0;
            phase_out_q <= '0;
            voice_out_q <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= '0;
                inc_q[v]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            phase_out_q <= phase_out_d;
            voice_out_q <= voice_out_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            overrun_q   <= overrun_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= phase_d[v];
                inc_q[v]   <= inc_d[v];
            end
        end
    end

    assign cmd_ready_out   = (state_q == IDLE);
    assign phase_out       = phase_out_q;
    assign voice_out       = voice_out_q;
    assign phase_valid_out = valid_q;
    assign last_out        = last_q;
    assign active_mask_out = active_q;
    assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_poly_phase_accumulator.sv
// Directed bench for poly_phase_accumulator; a second instance covers phase-continue retrigger.
module tb_poly_phase_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_voice = '0;
    logic [6:0]  cmd_note = '0;
    logic        cmd_gate = 1'b0;

    logic        ready_a, valid_a, last_a, overrun_a;
    logic [31:0] phase_a;
    logic [2:0]  voice_a;
    logic [7:0]  mask_a;

    logic        ready_b, valid_b, last_b, overrun_b;
    logic [31:0] phase_b;
    logic [2:0]  voice_b;
    logic [7:0]  mask_b;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          vcnt   = 0;
    logic [31:0] got_a [8];
    logic [31:0] got_b [8];

    always #5 clk = ~clk;

    poly_phase_accumulator #(
        .NUM_VOICES(8), .PHASE_WIDTH(32), .SAMPLE_RATE_HZ(16384), .PHASE_RESET_ON_NOTE(1'b1)
    ) dut_a (
        .clk_in(clk), .rst_in(rst), .sample_tick_in(tick),
        .cmd_valid_in(cmd_valid), .cmd_ready_out(ready_a), .cmd_voice_in(cmd_voice),
        .cmd_note_in(cmd_note), .cmd_gate_in(cmd_gate),
        .phase_out(phase_a), .voice_out(voice_a), .phase_valid_out(valid_a),
        .last_out(last_a), .active_mask_out(mask_a), .overrun_out(overrun_a)
    );

    poly_phase_accumulator #(
        .NUM_VOICES(8), .PHASE_WIDTH(32), .SAMPLE_RATE_HZ(16384), .PHASE_RESET_ON_NOTE(1'b0)
    ) dut_b (
        .clk_in(clk), .rst_in(rst), .sample_tick_in(tick),
        .cmd_valid_in(cmd_valid), .cmd_ready_out(ready_b), .cmd_voice_in(cmd_voice),
        .cmd_note_in(cmd_note), .cmd_gate_in(cmd_gate),
        .phase_out(phase_b), .voice_out(voice_b), .phase_valid_out(valid_b),
        .last_out(last_b), .active_mask_out(mask_b), .overrun_out(overrun_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 ns after the edge, logging any emitted slot.
    task automatic step();
        @(posedge clk);
        #1;
        if (valid_a) begin
            vcnt++;
            got_a[voice_a] = phase_a;
        end
        if (valid_b) got_b[voice_b] = phase_b;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; cmd_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        for (int v = 0; v < 8; v++) begin
            got_a[v] = '0;
            got_b[v] = '0;
        end
    endtask

    task automatic send_cmd(input int v, input int note, input bit gate);
        cmd_voice = 3'(v); cmd_note = 7'(note); cmd_gate = gate; cmd_valid = 1'b1;
        for (int n = 0; n < 30 && !ready_a; n++) step();
        chk("cmd_ready_wait", ready_a, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic do_sweep();
        vcnt = 0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        cmd_valid = 1'b0;
        chk("ready_low_sweep", ready_a, 0);
        chk("valid_lat", valid_a, 0);
        for (int v = 0; v < 8; v++) begin
            step();
            chk("slot_valid", valid_a, 1);
            chk("slot_voice", voice_a, v);
            chk("slot_last", last_a, (v == 7) ? 1 : 0);
            if (v == 0) chk("ready_low_first", ready_a, 0);
        end
        step();
        chk("valid_end", valid_a, 0);
        chk("ready_idle", ready_a, 1);
        chk("valid_count", vcnt, 8);
    endtask

    initial begin
        int n;

        // Reset values
        do_reset();
        chk("rst_phase", phase_a, 0);
        chk("rst_voice", voice_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_last", last_a, 0);
        chk("rst_mask", mask_a, 0);
        chk("rst_overrun", overrun_a, 0);
        chk("rst_ready", ready_a, 1);

        // Single voice, A4, one tick
        send_cmd(0, 69, 1'b1);
        chk("mask_v0", mask_a, 8'h01);
        do_sweep();
        chk("a4_v0", got_a[0], 32'd115343360);
        for (int v = 1; v < 8; v++) chk("idle_voice_zero", got_a[v], 0);

        // Two voices, three ticks, then note-off
        do_reset();
        send_cmd(0, 69, 1'b1);
        send_cmd(3, 57, 1'b1);
        repeat (3) do_sweep();
        chk("3tick_v0", got_a[0], 32'd346030080);
        chk("3tick_v3", got_a[3], 32'd173015040);
        send_cmd(0, 0, 1'b0);
        chk("mask_off", mask_a, 8'h08);
        do_sweep();
        chk("off_v0", got_a[0], 0);
        chk("4tick_v3", got_a[3], 32'd230686720);

        // Wrap-around at the top note and the smallest increment at note 0
        do_reset();
        send_cmd(1, 127, 1'b1);
        send_cmd(2, 0, 1'b1);
        repeat (2) do_sweep();
        chk("wrap_n127", got_a[1], 32'd2281624804);
        chk("n0_2tick", got_a[2], 32'd4286472);

        // Tick three cycles after the previous one
        do_reset();
        send_cmd(0, 69, 1'b1);
        vcnt = 0;
        tick = 1'b1; step();
        tick = 1'b0; step(); step();
        tick = 1'b1; step();
        tick = 1'b0;
        repeat (12) step();
        chk("ovr_valid_count", vcnt, 8);
        chk("ovr_flag", overrun_a, 1);
        chk("ovr_v0_once", got_a[0], 32'd115343360);
        do_sweep();
        chk("ovr_sticky", overrun_a, 1);
        chk("ovr_v0_twice", got_a[0], 32'd230686720);

        // Command held through a sweep, then same-cycle tick and note-on
        do_reset();
        tick = 1'b1; step();
        tick = 1'b0;
        cmd_voice = 3'd2; cmd_note = 7'd69; cmd_gate = 1'b1; cmd_valid = 1'b1;
        chk("held_ready_low", ready_a, 0);
        n = 0;
        while (!ready_a && n < 30) begin
            step();
            n++;
        end
        chk("held_wait_cycles", n, 8);
        chk("held_mask_before", mask_a, 0);
        step();
        cmd_valid = 1'b0;
        chk("held_mask_after", mask_a, 8'h04);
        cmd_voice = 3'd5; cmd_note = 7'd69; cmd_gate = 1'b1; cmd_valid = 1'b1;
        do_sweep();
        chk("same_cycle_v5", got_a[5], 32'd115343360);
        chk("held_v2", got_a[2], 32'd115343360);
        chk("same_cycle_mask", mask_a, 8'h24);

        // Retrigger mid-note: instance b keeps the phase, instance a clears it
        do_reset();
        send_cmd(0, 69, 1'b1);
        repeat (2) do_sweep();
        send_cmd(0, 57, 1'b1);
        do_sweep();
        chk("retrig_clear", got_a[0], 32'd57671680);
        chk("retrig_keep", got_b[0], 32'd288358400);

        // Reset in the middle of a sweep
        do_reset();
        send_cmd(0, 69, 1'b1);
        tick = 1'b1; step();
        tick = 1'b0; step(); step();
        chk("mid_valid_pre", valid_a, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", valid_a, 0);
        chk("mid_rst_phase", phase_a, 0);
        chk("mid_rst_voice", voice_a, 0);
        chk("mid_rst_mask", mask_a, 0);
        chk("mid_rst_ready", ready_a, 1);
        rst = 1'b0;
        vcnt = 0;
        repeat (10) step();
        chk("mid_rst_no_valid", vcnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
